load_store_unit: RTL and testbench

- Multi-cycle load/store unit between the execute-stage ALU result and a handshaked data memory port.
- Supports RV32I LB/LH/LW/LBU/LHU/SB/SH/SW.
- Generates byte enables and lane-shifted write data; sign/zero-extends load data.
- Stalls the core until each access completes, and bounds memory waits with a timeout counter.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I opcodes, funct3 encodings,
// FSM state encoding and legality helpers.
package lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    function automatic logic funct3_illegal(input logic is_load, input logic [2:0] funct3);
        if (is_load)
            return !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        return !(funct3 inside {F3_SB, F3_SH, F3_SW});
    endfunction

    // Size is carried in funct3[1:0] for both loads and stores.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated write data for stores,
// byte/half selection with sign or zero extension for loads.
module lsu_lane_align (
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Half accesses ignore addr_lo[0], word accesses ignore both bits.
    assign byte_sel = 8'(rdata >> {addr_lo, 3'b000});
    assign half_sel = 16'(rdata >> {addr_lo[1], 4'b0000});

    always_comb begin
        be         = '0;
        lane_wdata = '0;
        load_data  = '0;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                lane_wdata = {2{wdata[15:0]}};
                load_data  = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            2'b10: begin
                be         = 4'b1111;
                lane_wdata = wdata;
                load_data  = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit with handshaked memory port and timeout.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses abort with misalign_o.
//
// state | meaning
// IDLE  | waiting for a load/store from the core
// REQ   | mem_req_o high, waiting for mem_gnt_i
// WAIT  | load granted, waiting for mem_rvalid_i
// DONE  | one-cycle completion, result/error presented
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);

    lsu_state_t      state, next_state;
    logic            is_load_q;
    logic [2:0]      funct3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [TO_W-1:0] cnt;

    logic        start;
    logic        bad_op;
    logic        timed_out;
    logic        capture;
    logic        to_abort;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    assign start     = valid_i & (is_load_i | is_store_i);
    assign timed_out = cnt == TO_W'(TIMEOUT - 1);

`ifdef MISALIGN_TRAP_EN
    logic mis_op;
    logic misalign_q;

    assign mis_op = ~funct3_illegal(is_load_i, funct3_i) & misaligned(funct3_i, addr_i[1:0]);
    assign bad_op = funct3_illegal(is_load_i, funct3_i) | mis_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (state == ST_IDLE && start)
            misalign_q <= mis_op;
    end

    assign misalign_o = done_o & misalign_q;
`else
    assign bad_op = funct3_illegal(is_load_i, funct3_i);
`endif

    lsu_lane_align u_align (
        .addr_lo    (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .rdata      (mem_rdata_i),
        .be         (lane_be),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            is_load_q <= 1'b0;
            funct3_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && start) begin
                is_load_q <= is_load_i;
                funct3_q  <= funct3_i;
                addr_q    <= addr_i;
                wdata_q   <= wdata_i;
                rdata_q   <= '0;
                err_q     <= bad_op;
                cnt       <= '0;
            end else if (state == ST_REQ || state == ST_WAIT) begin
                cnt <= cnt + TO_W'(1);
                if (capture)
                    rdata_q <= load_data;
                if (to_abort)
                    err_q <= 1'b1;
            end
        end
    end

    // A load granted without data on the last allowed cycle still times out.
    always_comb begin
        next_state = state;
        stall_o    = 1'b0;
        capture    = 1'b0;
        to_abort   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    stall_o    = 1'b1;
                    next_state = bad_op ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall_o = 1'b1;
                if (mem_gnt_i && !is_load_q) begin
                    next_state = ST_DONE;
                end else if (mem_gnt_i && mem_rvalid_i) begin
                    capture    = 1'b1;
                    next_state = ST_DONE;
                end else if (timed_out) begin
                    to_abort   = 1'b1;
                    next_state = ST_DONE;
                end else if (mem_gnt_i) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                if (mem_rvalid_i) begin
                    capture    = 1'b1;
                    next_state = ST_DONE;
                end else if (timed_out) begin
                    to_abort   = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    assign done_o      = state == ST_DONE;
    assign rdata_o     = done_o ? rdata_q : '0;
    assign err_o       = done_o & err_q;
    assign mem_req_o   = state == ST_REQ;
    assign mem_we_o    = mem_req_o & ~is_load_q;
    assign mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : '0;
    assign mem_be_o    = mem_req_o ? lane_be : '0;
    assign mem_wdata_o = mem_req_o ? lane_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops
// checked against a cycle-level behavioural model of each access.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        is_load_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .is_load_i    (is_load_i),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    typedef struct {
        int          done_cyc;
        bit          err;
        logic [31:0] rdata;
        bit          mis;
        int          req_cycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          we;
        bit          stall_ok;
        bit          hold_ok;
        bit          post_ok;
    } res_t;

    // Expected outcome of one access; cycle 0 is the IDLE cycle presenting valid_i,
    // memory grants in REQ cycle g and returns data r cycles after the grant.
    function automatic res_t model(input bit ld, input bit [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd,
                                   input int g, input int r);
        res_t        e;
        bit          legal;
        int          off;
        int          lat;
        logic [31:0] lane;
        e.done_cyc = 0; e.err = 0; e.rdata = 0; e.mis = 0; e.req_cycles = 0;
        e.addr = 0; e.be = 0; e.wdata = 0; e.we = 0;
        e.stall_ok = 1; e.hold_ok = 1; e.post_ok = 1;
        legal = ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
`ifdef MISALIGN_TRAP_EN
        if (legal)
            e.mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
`endif
        if (!legal || e.mis) begin
            e.done_cyc = 1;
            e.err = 1;
            return e;
        end
        e.we   = !ld;
        e.addr = a & ~32'h3;
        if (f3[1:0] == 2'b00) begin
            off     = int'(a % 4);
            e.be    = 4'(1 << off);
            e.wdata = {24'b0, wd[7:0]} * 32'h01010101;
            lane    = (rd >> (8 * off)) & 32'hFF;
            e.rdata = (!f3[2] && lane >= 128) ? lane + 32'hFFFFFF00 : lane;
        end else if (f3[1:0] == 2'b01) begin
            off     = (a[1] == 1'b1) ? 2 : 0;
            e.be    = 4'(3 << off);
            e.wdata = {16'b0, wd[15:0]} * 32'h00010001;
            lane    = (rd >> (8 * off)) & 32'hFFFF;
            e.rdata = (!f3[2] && lane >= 32768) ? lane + 32'hFFFF0000 : lane;
        end else begin
            e.be    = 4'hF;
            e.wdata = wd;
            e.rdata = rd;
        end
        lat = ld ? g + r : g;
        if (lat <= TIMEOUT - 1) begin
            e.done_cyc = lat + 2;
        end else begin
            e.done_cyc = TIMEOUT + 1;
            e.err      = 1;
            e.rdata    = 0;
        end
        e.req_cycles = ((g < TIMEOUT) ? g : TIMEOUT - 1) + 1;
        return e;
    endfunction

    // Drives one access and records what the DUT did; b2b skips the idle cycles
    // afterwards so the next access starts in the IDLE cycle right after DONE.
    task automatic run_op(input bit ld, input bit [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int g, input int r, input bit b2b, output res_t o);
        bit first_req = 1;
        o.done_cyc = -1; o.err = 0; o.rdata = 0; o.mis = 0; o.req_cycles = 0;
        o.addr = 0; o.be = 0; o.wdata = 0; o.we = 0;
        o.stall_ok = 1; o.hold_ok = 1; o.post_ok = 1;
        @(posedge clk); #1;
        valid_i = 1; is_load_i = ld; is_store_i = !ld; funct3_i = f3;
        addr_i = a; wdata_i = wd; mem_rdata_i = rd;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            mem_gnt_i    = (cyc == 1 + g);
            mem_rvalid_i = ld && (cyc == 1 + g + r);
            #1;
            if (done_o) begin
                o.done_cyc = cyc;
                o.err      = err_o;
                o.rdata    = rdata_o;
`ifdef MISALIGN_TRAP_EN
                o.mis      = misalign_o;
`endif
                if (stall_o || mem_req_o) o.stall_ok = 0;
                break;
            end
            if (!stall_o) o.stall_ok = 0;
            if (mem_req_o) begin
                o.req_cycles++;
                if (first_req) begin
                    o.addr = mem_addr_o; o.be = mem_be_o; o.wdata = mem_wdata_o; o.we = mem_we_o;
                    first_req = 0;
                end else if (o.addr !== mem_addr_o || o.be !== mem_be_o ||
                             o.wdata !== mem_wdata_o || o.we !== mem_we_o) begin
                    o.hold_ok = 0;
                end
            end
        end
        mem_gnt_i = 0;
        mem_rvalid_i = 0;
        if (!b2b) begin
            @(posedge clk); #1;
            valid_i = 0;
            mem_rvalid_i = ld;
            #1;
            if (done_o || stall_o || mem_req_o) o.post_ok = 0;
            @(posedge clk); #1;
            mem_rvalid_i = 0;
            #1;
            if (done_o || stall_o || mem_req_o) o.post_ok = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1; valid_i = 0; is_load_i = 0; is_store_i = 0; funct3_i = 0;
        addr_i = 0; wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if ({stall_o, done_o, rdata_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: done=%b stall=%b req=%b rdata=%h addr=%h required all zero",
                     done_o, stall_o, mem_req_o, rdata_o, mem_addr_o);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_store_word();
        res_t o;
        run_op(0, 3'b010, 32'h70, 32'hDEADBEEF, 32'h0, 0, 0, 0, o);
        vectors++;
        if (o.done_cyc !== 2 || o.err !== 0) begin
            miscompares++;
            $display("FAIL sw_latency: done_cyc=%0d err=%b required 2/0", o.done_cyc, o.err);
        end
        vectors++;
        if (o.addr !== 32'h70 || o.be !== 4'b1111 || o.wdata !== 32'hDEADBEEF || o.we !== 1) begin
            miscompares++;
            $display("FAIL sw_fields: addr=%h be=%b wdata=%h we=%b required 70/1111/deadbeef/1",
                     o.addr, o.be, o.wdata, o.we);
        end
        vectors++;
        if (!o.stall_ok || o.req_cycles !== 1) begin
            miscompares++;
            $display("FAIL sw_stall: stall_ok=%b req_cycles=%0d required 1/1", o.stall_ok, o.req_cycles);
        end
    endtask

    task automatic test_load_byte();
        res_t o;
        run_op(1, 3'b000, 32'h73, 32'h0, 32'h80FF1234, 0, 1, 0, o);
        vectors++;
        if (o.done_cyc !== 3 || o.rdata !== 32'hFFFFFF80 || o.err !== 0) begin
            miscompares++;
            $display("FAIL lb_sext: done_cyc=%0d rdata=%h err=%b required 3/ffffff80/0", o.done_cyc, o.rdata, o.err);
        end
        vectors++;
        if (o.addr !== 32'h70 || o.be !== 4'b1000 || o.we !== 0) begin
            miscompares++;
            $display("FAIL lb_fields: addr=%h be=%b we=%b required 70/1000/0", o.addr, o.be, o.we);
        end
        run_op(1, 3'b100, 32'h73, 32'h0, 32'h80FF1234, 0, 1, 0, o);
        vectors++;
        if (o.done_cyc !== 3 || o.rdata !== 32'h00000080) begin
            miscompares++;
            $display("FAIL lbu_zext: done_cyc=%0d rdata=%h required 3/00000080", o.done_cyc, o.rdata);
        end
    endtask

    task automatic test_store_half();
        res_t o;
        run_op(0, 3'b001, 32'h42, 32'h0000ABCD, 32'h0, 2, 0, 0, o);
        vectors++;
        if (o.addr !== 32'h40 || o.be !== 4'b1100 || o.wdata !== 32'hABCDABCD) begin
            miscompares++;
            $display("FAIL sh_fields: addr=%h be=%b wdata=%h required 40/1100/abcdabcd", o.addr, o.be, o.wdata);
        end
        vectors++;
        if (o.done_cyc !== 4 || !o.hold_ok || o.req_cycles !== 3) begin
            miscompares++;
            $display("FAIL sh_hold: done_cyc=%0d hold_ok=%b req_cycles=%0d required 4/1/3",
                     o.done_cyc, o.hold_ok, o.req_cycles);
        end
    endtask

    task automatic test_timeout();
        res_t o;
        run_op(1, 3'b010, 32'h300, 32'h0, 32'h12345678, 20, 0, 0, o);
        vectors++;
        if (o.done_cyc !== TIMEOUT + 1 || o.err !== 1 || o.rdata !== 0) begin
            miscompares++;
            $display("FAIL timeout_gnt: done_cyc=%0d err=%b rdata=%h required %0d/1/0",
                     o.done_cyc, o.err, o.rdata, TIMEOUT + 1);
        end
        vectors++;
        if (o.req_cycles !== TIMEOUT || !o.post_ok) begin
            miscompares++;
            $display("FAIL timeout_req: req_cycles=%0d post_ok=%b required %0d/1", o.req_cycles, o.post_ok, TIMEOUT);
        end
        run_op(1, 3'b010, 32'h304, 32'h0, 32'h12345678, 3, 30, 0, o);
        vectors++;
        if (o.done_cyc !== TIMEOUT + 1 || o.err !== 1 || o.rdata !== 0 || !o.post_ok) begin
            miscompares++;
            $display("FAIL timeout_rvalid: done_cyc=%0d err=%b rdata=%h post_ok=%b required %0d/1/0/1",
                     o.done_cyc, o.err, o.rdata, o.post_ok, TIMEOUT + 1);
        end
        run_op(1, 3'b010, 32'h308, 32'h0, 32'hCAFEF00D, 5, TIMEOUT - 6, 0, o);
        vectors++;
        if (o.done_cyc !== TIMEOUT + 1 || o.err !== 0 || o.rdata !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL timeout_edge: done_cyc=%0d err=%b rdata=%h required %0d/0/cafef00d",
                     o.done_cyc, o.err, o.rdata, TIMEOUT + 1);
        end
    endtask

    task automatic test_illegal();
        res_t o;
        run_op(1, 3'b011, 32'h10, 32'h0, 32'hFFFFFFFF, 0, 0, 0, o);
        vectors++;
        if (o.done_cyc !== 1 || o.err !== 1 || o.req_cycles !== 0 || !o.stall_ok || o.rdata !== 0) begin
            miscompares++;
            $display("FAIL illegal_load: done_cyc=%0d err=%b req_cycles=%0d stall_ok=%b rdata=%h required 1/1/0/1/0",
                     o.done_cyc, o.err, o.req_cycles, o.stall_ok, o.rdata);
        end
        run_op(0, 3'b100, 32'h10, 32'h1, 32'h0, 0, 0, 0, o);
        vectors++;
        if (o.done_cyc !== 1 || o.err !== 1 || o.req_cycles !== 0) begin
            miscompares++;
            $display("FAIL illegal_store: done_cyc=%0d err=%b req_cycles=%0d required 1/1/0",
                     o.done_cyc, o.err, o.req_cycles);
        end
    endtask

    task automatic test_misalign();
        res_t o;
        run_op(1, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, 1, 0, o);
`ifdef MISALIGN_TRAP_EN
        vectors++;
        if (o.done_cyc !== 1 || o.err !== 1 || o.mis !== 1 || o.req_cycles !== 0 || o.rdata !== 0) begin
            miscompares++;
            $display("FAIL misalign_trap: done_cyc=%0d err=%b mis=%b req_cycles=%0d rdata=%h required 1/1/1/0/0",
                     o.done_cyc, o.err, o.mis, o.req_cycles, o.rdata);
        end
`else
        vectors++;
        if (o.done_cyc !== 3 || o.err !== 0 || o.addr !== 32'h100 || o.be !== 4'hF || o.rdata !== 32'h11223344) begin
            miscompares++;
            $display("FAIL misalign_force: done_cyc=%0d err=%b addr=%h be=%b rdata=%h required 3/0/100/1111/11223344",
                     o.done_cyc, o.err, o.addr, o.be, o.rdata);
        end
`endif
    endtask

    task automatic test_reset_mid_op();
        res_t o;
        @(posedge clk); #1;
        valid_i = 1; is_load_i = 1; is_store_i = 0; funct3_i = 3'b010; addr_i = 32'h200;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 32'h55AA55AA;
        @(posedge clk); #1;
        mem_gnt_i = 1;
        @(posedge clk); #1;
        mem_gnt_i = 0;
        #1;
        vectors++;
        if (stall_o !== 1 || mem_req_o !== 0 || done_o !== 0) begin
            miscompares++;
            $display("FAIL rst_pre_wait: stall=%b req=%b done=%b required 1/0/0", stall_o, mem_req_o, done_o);
        end
        rst = 1; valid_i = 0;
        #1;
        vectors++;
        if ({stall_o, done_o, rdata_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_op: stall=%b done=%b req=%b rdata=%h required all zero",
                     stall_o, done_o, mem_req_o, rdata_o);
        end
        @(posedge clk); #1;
        rst = 0; mem_rvalid_i = 1;
        #1;
        vectors++;
        if (done_o !== 0 || stall_o !== 0 || mem_req_o !== 0) begin
            miscompares++;
            $display("FAIL rst_stray_rvalid: done=%b stall=%b req=%b required 0/0/0", done_o, stall_o, mem_req_o);
        end
        @(posedge clk); #1;
        mem_rvalid_i = 0;
        #1;
        vectors++;
        if (done_o !== 0) begin
            miscompares++;
            $display("FAIL rst_stray_done: done=%b required 0", done_o);
        end
        run_op(1, 3'b101, 32'h206, 32'h0, 32'h9ABC1234, 1, 0, 0, o);
        vectors++;
        if (o.done_cyc !== 3 || o.err !== 0 || o.rdata !== 32'h00009ABC) begin
            miscompares++;
            $display("FAIL rst_recover: done_cyc=%0d err=%b rdata=%h required 3/0/00009abc", o.done_cyc, o.err, o.rdata);
        end
    endtask

    task automatic test_back_to_back();
        res_t o;
        res_t e;
        bit          ld_l [3] = '{0, 1, 0};
        bit [2:0]    f3_l [3] = '{3'b010, 3'b001, 3'b000};
        logic [31:0] a_l  [3] = '{32'h500, 32'h502, 32'h503};
        for (int i = 0; i < 3; i++) begin
            e = model(ld_l[i], f3_l[i], a_l[i], 32'h13579BDF + i, 32'hF00D8421, 0, 0);
            run_op(ld_l[i], f3_l[i], a_l[i], 32'h13579BDF + i, 32'hF00D8421, 0, 0, i < 2, o);
            vectors++;
            if (o.done_cyc !== e.done_cyc || o.err !== e.err || o.be !== e.be ||
                (ld_l[i] && o.rdata !== e.rdata) || (!ld_l[i] && o.wdata !== e.wdata)) begin
                miscompares++;
                $display("FAIL b2b_%0d: done_cyc=%0d err=%b be=%b rdata=%h wdata=%h required %0d/%b/%b/%h/%h",
                         i, o.done_cyc, o.err, o.be, o.rdata, o.wdata, e.done_cyc, e.err, e.be, e.rdata, e.wdata);
            end
        end
    endtask

    task automatic test_random();
        res_t        o;
        res_t        e;
        bit          ld;
        bit [2:0]    f3;
        logic [31:0] a, wd, rd;
        int          g, r;
        bit [2:0]    ld_set [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 150; n++) begin
            ld = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
                f3 = 3'($urandom_range(0, 7));
            else if (ld)
                f3 = ld_set[$urandom_range(0, 4)];
            else
                f3 = 3'($urandom_range(0, 2));
            a  = $urandom;
            wd = $urandom;
            rd = $urandom;
            g  = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
            r  = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
            e  = model(ld, f3, a, wd, rd, g, r);
            run_op(ld, f3, a, wd, rd, g, r, $urandom_range(0, 3) == 0, o);
            vectors++;
            if (o.done_cyc !== e.done_cyc || o.err !== e.err || o.mis !== e.mis || o.req_cycles !== e.req_cycles) begin
                miscompares++;
                $display("FAIL rand_%0d_ctrl: done_cyc=%0d err=%b mis=%b req=%0d required %0d/%b/%b/%0d (ld=%b f3=%0d a=%h g=%0d r=%0d)",
                         n, o.done_cyc, o.err, o.mis, o.req_cycles, e.done_cyc, e.err, e.mis, e.req_cycles, ld, f3, a, g, r);
            end
            vectors++;
            if (!o.stall_ok || !o.hold_ok || !o.post_ok) begin
                miscompares++;
                $display("FAIL rand_%0d_hs: stall_ok=%b hold_ok=%b post_ok=%b required 1/1/1",
                         n, o.stall_ok, o.hold_ok, o.post_ok);
            end
            if (e.req_cycles > 0) begin
                vectors++;
                if (o.addr !== e.addr || o.be !== e.be || o.we !== e.we || (!ld && o.wdata !== e.wdata)) begin
                    miscompares++;
                    $display("FAIL rand_%0d_bus: addr=%h be=%b we=%b wdata=%h required %h/%b/%b/%h",
                             n, o.addr, o.be, o.we, o.wdata, e.addr, e.be, e.we, e.wdata);
                end
            end
            if (ld || e.err) begin
                vectors++;
                if (o.rdata !== e.rdata) begin
                    miscompares++;
                    $display("FAIL rand_%0d_rdata: rdata=%h required %h (f3=%0d a=%h rd=%h)", n, o.rdata, e.rdata, f3, a, rd);
                end
            end
        end
        valid_i = 0;
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half();
        test_timeout();
        test_illegal();
        test_misalign();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
